// File: rtl/issue_ctrl_if.sv
// ============================================================================
// Module      : issue_ctrl_if
// Description : Decode-stage handshake between the fetch/decode datapath and
//               the issue controller: the presented instruction and the
//               enables/stall returned for it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface issue_ctrl_if;
  logic        insn_valid;
  logic [31:0] insn;
  logic        enable_fetch;
  logic        enable_decode;
  logic        stall;

  // Datapath side: presents the instruction, obeys the enables
  modport master (
    output insn_valid,
    output insn,
    input  enable_fetch,
    input  enable_decode,
    input  stall
  );

  // Controller side: inspects the instruction, drives the enables
  modport slave (
    input  insn_valid,
    input  insn,
    output enable_fetch,
    output enable_decode,
    output stall
  );
endinterface

`default_nettype wire

// File: rtl/issue_ctrl.sv
// ============================================================================
// Module      : issue_ctrl
// Description : Issue/stall controller for the MIPS fetch and decode stages.
//               Holds issue on load-use hazards and on accesses to the
//               multi-cycle MULT/DIV unit (and HI/LO) while it is busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  issue_ctrl_if.slave  dec,
  output logic         md_busy,
  output logic [1:0]   state_out
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_LOAD_STALL = 2'd2;
  localparam logic [1:0] ST_MD_WAIT    = 2'd3;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_load_valid_q, last_load_valid_d;
  logic [4:0]       last_load_rt_q, last_load_rt_d;

  logic [5:0] op, func;
  logic [4:0] rs, rt;
  logic       is_load, reads_rt, is_mult, is_div, is_md, is_hilo;
  logic       load_haz, md_haz, any_haz, issue;
  logic       en_fetch, en_decode, stall_o;
  logic       unused_insn_bits;

  // Immediate/shamt/rd bits play no part in hazard detection
  assign unused_insn_bits = ^dec.insn[15:6];

  // Decode the presented instruction and evaluate both hazards against it
  always_comb begin
    op       = dec.insn[31:26];
    rs       = dec.insn[25:21];
    rt       = dec.insn[20:16];
    func     = dec.insn[5:0];
    is_load  = (op == 6'b100011) || (op == 6'b100000) || (op == 6'b100100);
    reads_rt = (op == 6'b000000) || (op == 6'b101011) || (op == 6'b101000) ||
               (op == 6'b000100) || (op == 6'b000101);
    is_mult  = (op == 6'b000000) && ((func == 6'b011000) || (func == 6'b011001));
    is_div   = (op == 6'b000000) && ((func == 6'b011010) || (func == 6'b011011));
    is_md    = is_mult || is_div;
    is_hilo  = (op == 6'b000000) && ((func == 6'b010000) || (func == 6'b010010));
    md_busy  = (cnt_q != '0);
    load_haz = dec.insn_valid && last_load_valid_q &&
               ((rs == last_load_rt_q) || (reads_rt && (rt == last_load_rt_q)));
    md_haz   = dec.insn_valid && md_busy && (is_md || is_hilo);
    any_haz  = load_haz || md_haz;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides everything, md hazard beats load hazard
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (md_haz)        state_d = ST_MD_WAIT;
          else if (load_haz) state_d = ST_LOAD_STALL;
        end
        ST_LOAD_STALL: state_d = ST_RUN;
        ST_MD_WAIT:    if (cnt_q == '0) state_d = ST_RUN;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: only RUN may issue; other states hold a valid insn as stalled
  always_comb begin
    en_fetch  = 1'b0;
    en_decode = 1'b0;
    stall_o   = 1'b0;
    if (state_q == ST_RUN) begin
      en_fetch  = !any_haz;
      en_decode = !any_haz;
      stall_o   = any_haz;
    end else begin
      stall_o   = dec.insn_valid;
    end
  end

  assign dec.enable_fetch  = en_fetch;
  assign dec.enable_decode = en_decode;
  assign dec.stall         = stall_o;
  assign state_out         = state_q;
  assign issue             = en_decode && dec.insn_valid;

  // Next values for load tracking and the mult/div busy counter
  always_comb begin
    last_load_valid_d = issue && is_load && (rt != 5'd0) && !stop;
    last_load_rt_d    = issue ? rt : last_load_rt_q;
    if (issue && is_mult) begin
      cnt_d = MULT_LOAD;
    end else if (issue && is_div) begin
      cnt_d = DIV_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tracking registers; the counter keeps draining regardless of state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q             <= '0;
      last_load_valid_q <= 1'b0;
      last_load_rt_q    <= 5'd0;
    end else begin
      cnt_q             <= cnt_d;
      last_load_valid_q <= last_load_valid_d;
      last_load_rt_q    <= last_load_rt_d;
    end
  end

endmodule

`default_nettype wire
